// File: rtl/rslatch_bank.sv
// Bank of N clocked RS latch channels with a configurable conflict policy,
// sticky conflict flags, a saturating conflict counter and an arm/decide window.

module rslatch_lane #(
    parameter int MODE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_s,
    input  logic i_r,
    input  logic i_clr_err,
    output logic o_q,
    output logic o_qb,
    output logic o_err,
    output logic o_conflict,
    output logic o_wr
);
    logic r_q, r_qb, r_err;
    logic w_q_nxt, w_qb_nxt;

    assign o_conflict = i_s & i_r;
    assign o_wr       = i_s | i_r;

    // Code is {set-line, reset-line}: 01 sets, 10 resets, 11 is the conflict.
    always_comb begin
        w_q_nxt  = r_q;
        w_qb_nxt = r_qb;
        case ({i_s, i_r})
            2'b01: begin w_q_nxt = 1'b1; w_qb_nxt = 1'b0; end
            2'b10: begin w_q_nxt = 1'b0; w_qb_nxt = 1'b1; end
            2'b11: begin
                case (MODE)
                    0:       begin w_q_nxt = 1'b1; w_qb_nxt = 1'b0; end
                    1:       begin w_q_nxt = 1'b0; w_qb_nxt = 1'b1; end
                    2:       begin w_q_nxt = r_q;  w_qb_nxt = r_qb; end
                    default: begin w_q_nxt = 1'b1; w_qb_nxt = 1'b1; end
                endcase
            end
            default: begin w_q_nxt = r_q; w_qb_nxt = r_qb; end
        endcase
    end

    // A conflict in the same cycle as clr_err wins so the event is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= 1'b0;
            r_qb  <= 1'b1;
            r_err <= 1'b0;
        end else begin
            r_q  <= w_q_nxt;
            r_qb <= w_qb_nxt;
            if (o_conflict)
                r_err <= 1'b1;
            else if (i_clr_err)
                r_err <= 1'b0;
        end
    end

    assign o_q   = r_q;
    assign o_qb  = r_qb;
    assign o_err = r_err;
endmodule

module rslatch_bank #(
    parameter int N     = 4,
    parameter int MODE  = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     setb,
    input  logic [N-1:0]     resetb,
    input  logic             arm,
    input  logic             clr_err,
    output logic [N-1:0]     q,
    output logic [N-1:0]     qb,
    output logic [N-1:0]     err,
    output logic [CNT_W-1:0] conflict_cnt,
    output logic             dec_vld
);
    localparam int SW = ((CNT_W > 6) ? CNT_W : 6) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    logic [N-1:0]     w_conf, w_wr;
    logic [5:0]       w_pop;
    logic [SW-1:0]    w_sum;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_mask, w_mask_nxt;
    logic             w_all;
    state_t           r_state, w_state_nxt;

    for (genvar i = 0; i < N; i++) begin : g_lane
        rslatch_lane #(.MODE(MODE)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .i_s       (setb[i]),
            .i_r       (resetb[i]),
            .i_clr_err (clr_err),
            .o_q       (q[i]),
            .o_qb      (qb[i]),
            .o_err     (err[i]),
            .o_conflict(w_conf[i]),
            .o_wr      (w_wr[i])
        );
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N; i++)
            w_pop = w_pop + 6'(w_conf[i]);
    end

    // clr_err restarts the count from this cycle's conflicts instead of zero.
    always_comb begin
        w_sum = clr_err ? SW'(w_pop) : SW'(r_cnt) + SW'(w_pop);
        if (w_sum > SW'(CNT_MAX))
            w_cnt_nxt = CNT_MAX;
        else
            w_cnt_nxt = w_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else
            r_cnt <= w_cnt_nxt;
    end

    assign conflict_cnt = r_cnt;

    // The arm cycle's own writes count toward the window that arm opens.
    always_comb begin
        w_mask_nxt = r_mask;
        if (arm)
            w_mask_nxt = w_wr;
        else if (r_state == S_WAIT)
            w_mask_nxt = r_mask | w_wr;
    end

    assign w_all = &w_mask_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (arm) w_state_nxt = w_all ? S_DONE : S_WAIT;
            S_WAIT:  w_state_nxt = w_all ? S_DONE : S_WAIT;
            S_DONE:  w_state_nxt = arm ? (w_all ? S_DONE : S_WAIT) : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dec_vld = (r_state == S_DONE);
    end
endmodule

// File: tb/tb_rslatch_bank.sv
// Directed bench: five bank instances (all conflict policies plus a 2-bit
// counter) share one stimulus stream; expected values are hand-computed.

module tb_rslatch_bank;
    logic       clk = 1'b0;
    logic       rst, arm, clr_err;
    logic [3:0] setb, resetb;

    logic [3:0] q0, qb0, err0, q1, qb1, err1, q2, qb2, err2, q3, qb3, err3, qc, qbc, errc;
    logic [7:0] cnt0, cnt1, cnt2, cnt3;
    logic [1:0] cntc;
    logic       dv0, dv1, dv2, dv3, dvc;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rslatch_bank #(.N(4), .MODE(0), .CNT_W(8)) d0 (.clk(clk), .rst(rst), .setb(setb), .resetb(resetb),
        .arm(arm), .clr_err(clr_err), .q(q0), .qb(qb0), .err(err0), .conflict_cnt(cnt0), .dec_vld(dv0));
    rslatch_bank #(.N(4), .MODE(1), .CNT_W(8)) d1 (.clk(clk), .rst(rst), .setb(setb), .resetb(resetb),
        .arm(arm), .clr_err(clr_err), .q(q1), .qb(qb1), .err(err1), .conflict_cnt(cnt1), .dec_vld(dv1));
    rslatch_bank #(.N(4), .MODE(2), .CNT_W(8)) d2 (.clk(clk), .rst(rst), .setb(setb), .resetb(resetb),
        .arm(arm), .clr_err(clr_err), .q(q2), .qb(qb2), .err(err2), .conflict_cnt(cnt2), .dec_vld(dv2));
    rslatch_bank #(.N(4), .MODE(3), .CNT_W(8)) d3 (.clk(clk), .rst(rst), .setb(setb), .resetb(resetb),
        .arm(arm), .clr_err(clr_err), .q(q3), .qb(qb3), .err(err3), .conflict_cnt(cnt3), .dec_vld(dv3));
    rslatch_bank #(.N(4), .MODE(0), .CNT_W(2)) dc (.clk(clk), .rst(rst), .setb(setb), .resetb(resetb),
        .arm(arm), .clr_err(clr_err), .q(qc), .qb(qbc), .err(errc), .conflict_cnt(cntc), .dec_vld(dvc));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs set before step() are sampled on the next edge; checks run 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] s, input logic [3:0] r, input logic a, input logic c);
        setb = s; resetb = r; arm = a; clr_err = c;
    endtask

    initial begin
        rst = 1'b1;
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        step();
        check("rst_q", q0, 4'h0);
        check("rst_qb", qb0, 4'hF);
        check("rst_err", err0, 4'h0);
        check("rst_cnt", cnt0, 8'd0);
        check("rst_dv", dv0, 1'b0);
        rst = 1'b0;

        // Code 01 on every channel sets all latches
        drive(4'h0, 4'hF, 1'b0, 1'b0); step();
        check("set_q", q0, 4'hF);
        check("set_qb", qb0, 4'h0);
        check("set_err", err0, 4'h0);

        drive(4'hF, 4'h0, 1'b0, 1'b0); step();
        check("reset_q", q0, 4'h0);
        check("reset_qb", qb0, 4'hF);

        drive(4'b0101, 4'b1010, 1'b0, 1'b0); step();
        check("mix_q", q0, 4'b1010);
        check("mix_qb", qb0, 4'b0101);

        drive(4'h0, 4'h0, 1'b0, 1'b0); step();
        check("hold_q", q0, 4'b1010);

        // Channel 2 conflict under each policy
        drive(4'b0100, 4'b0100, 1'b0, 1'b0); step();
        check("m0_q", q0, 4'b1110);
        check("m0_qb", qb0, 4'b0001);
        check("m1_q", q1, 4'b1010);
        check("m1_qb", qb1, 4'b0101);
        check("m2_q", q2, 4'b1010);
        check("m2_qb", qb2, 4'b0101);
        check("m3_q", q3, 4'b1110);
        check("m3_qb", qb3, 4'b0101);
        check("m3_err", err3, 4'b0100);
        check("m3_cnt", cnt3, 8'd1);
        check("c2_cnt1", cntc, 2'd1);

        drive(4'b0100, 4'b0000, 1'b0, 1'b0); step();
        check("m3_rel_q", q3, 4'b1010);
        check("m3_rel_qb", qb3, 4'b0101);
        check("m3_err_sticky", err3, 4'b0100);

        drive(4'hF, 4'hF, 1'b0, 1'b0); step();
        check("all_cnt8", cnt0, 8'd5);
        check("all_cnt2_sat", cntc, 2'd3);
        check("all_err", err0, 4'hF);
        check("all_m1_q", q1, 4'h0);
        check("all_m3_qb", qb3, 4'hF);
        check("all_m2_q", q2, 4'b1010);

        step();
        check("all2_cnt8", cnt0, 8'd9);
        check("all2_cnt2_sat", cntc, 2'd3);

        drive(4'h0, 4'h0, 1'b0, 1'b1); step();
        check("clr_err", err0, 4'h0);
        check("clr_cnt8", cnt0, 8'd0);
        check("clr_cnt2", cntc, 2'd0);

        // clr_err together with a conflict on channel 1
        drive(4'b0010, 4'b0010, 1'b0, 1'b1); step();
        check("clrc_err", err0, 4'b0010);
        check("clrc_cnt", cnt0, 8'd1);
        check("clrc_cnt2", cntc, 2'd1);

        drive(4'h0, 4'h0, 1'b0, 1'b1); step();
        check("clr2_cnt", cnt0, 8'd0);

        // Window split across two write cycles
        drive(4'h0, 4'h0, 1'b1, 1'b0); step();
        check("win_arm_dv", dv0, 1'b0);
        drive(4'h0, 4'b0011, 1'b0, 1'b0); step();
        check("win_w1_dv", dv0, 1'b0);
        drive(4'h0, 4'b1100, 1'b0, 1'b0); step();
        check("win_done_dv", dv0, 1'b1);
        drive(4'h0, 4'h0, 1'b0, 1'b0); step();
        check("win_idle_dv", dv0, 1'b0);
        step();
        check("win_idle2_dv", dv0, 1'b0);

        // arm with a full write completes immediately
        drive(4'hF, 4'h0, 1'b1, 1'b0); step();
        check("armall_dv", dv0, 1'b1);
        drive(4'h0, 4'h0, 1'b0, 1'b0); step();
        check("armall_end_dv", dv0, 1'b0);

        // Re-arm in WAIT discards the earlier coverage
        drive(4'b0111, 4'h0, 1'b1, 1'b0); step();
        drive(4'h0, 4'h0, 1'b1, 1'b0); step();
        drive(4'h0, 4'b1000, 1'b0, 1'b0); step();
        check("rearm_dv", dv0, 1'b0);
        drive(4'b0111, 4'h0, 1'b0, 1'b0); step();
        check("rearm_done_dv", dv0, 1'b1);
        drive(4'h0, 4'h0, 1'b0, 1'b0); step();

        // Reset mid-window aborts the decision
        drive(4'h0, 4'h0, 1'b1, 1'b0); step();
        drive(4'h0, 4'b0111, 1'b0, 1'b0); step();
        check("abort_pre_dv", dv0, 1'b0);
        rst = 1'b1;
        drive(4'b0100, 4'b1100, 1'b1, 1'b0); step();
        check("abort_q", q0, 4'h0);
        check("abort_qb", qb0, 4'hF);
        check("abort_err", err0, 4'h0);
        check("abort_cnt", cnt0, 8'd0);
        check("abort_dv", dv0, 1'b0);
        rst = 1'b0;
        drive(4'h0, 4'b1000, 1'b0, 1'b0); step();
        check("abort_post_dv", dv0, 1'b0);
        check("abort_post_q", q0, 4'b1000);
        drive(4'h0, 4'h0, 1'b0, 1'b0); step();
        check("abort_post2_dv", dv0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
